// File: rtl/alu_types.sv
// Shared ALU types: operation select for the 32-bit alu and the arbiter FSM states.
package alu_types;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_control_t;

    localparam int ALU_CTRL_W = $bits(alu_control_t);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } alu_arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; overflow is signed overflow for ADD/SUB only,
// zero reflects the result and equal compares the raw operands.
module alu
    import alu_types::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_control_t control,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         equal
);

    logic [N-1:0] sum;
    logic [N-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (control)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_ADD: begin
                result   = sum;
                overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            ALU_SLT: result = N'($signed(a) < $signed(b));
            default: result = '0;
        endcase
    end

    assign zero  = (result == '0);
    assign equal = (a == b);

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: grants the first valid requester after ptr,
// wrapping modulo NREQ. Reusable by any shared-resource arbiter.
module rr_picker #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        // Walk from the farthest candidate to the nearest so the nearest valid one wins.
        for (int off = NREQ; off >= 1; off--) begin
            if (valid[(int'(ptr) + off) % NREQ]) begin
                grant_id = IDW'((int'(ptr) + off) % NREQ);
                any      = 1'b1;
            end
        end
        if (any) grant[grant_id] = 1'b1;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu among NREQ requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_STATS_EN to add the ops_count / ovf_count statistics ports.
module alu_arbiter
    import alu_types::*;
#(
    parameter  int N    = 32,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ),
    localparam int CW   = ALU_CTRL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*N-1:0]  req_a,
    input  logic [NREQ*N-1:0]  req_b,
    input  logic [NREQ*CW-1:0] req_control,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [N-1:0]       rsp_result,
    output logic               rsp_overflow,
    output logic               rsp_zero,
    output logic               rsp_equal
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]        ops_count,
    output logic [15:0]        ovf_count
`endif
);

    alu_arb_state_t state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    alu_control_t   op_ctrl_q, op_ctrl_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [N-1:0]   rsp_result_q, rsp_result_d;
    logic           rsp_overflow_q, rsp_overflow_d;
    logic           rsp_zero_q, rsp_zero_d;
    logic           rsp_equal_q, rsp_equal_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    logic            accept;
    logic            rsp_fire;
    logic [N-1:0]    alu_result;
    logic            alu_overflow, alu_zero, alu_equal;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .valid    (req_valid),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (grant_any)
    );

    alu #(.N(N)) u_alu (
        .a        (op_a_q),
        .b        (op_b_q),
        .control  (op_ctrl_q),
        .result   (alu_result),
        .overflow (alu_overflow),
        .zero     (alu_zero),
        .equal    (alu_equal)
    );

    assign accept   = (state_q == IDLE) && grant_any;
    assign rsp_fire = (state_q == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        // Ready is held low while reset is asserted, before any edge arrives.
        if (rst_n && state_q == IDLE) req_ready = grant;
    end

    always_comb begin
        // NOTE: every _d defaults to its _q so no branch infers a latch.
        rr_ptr_d       = rr_ptr_q;
        id_d           = id_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        op_ctrl_d      = op_ctrl_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_equal_d    = rsp_equal_q;
        if (accept) begin
            op_a_d    = req_a[int'(grant_id)*N +: N];
            op_b_d    = req_b[int'(grant_id)*N +: N];
            op_ctrl_d = alu_control_t'(req_control[int'(grant_id)*CW +: CW]);
            id_d      = grant_id;
            rr_ptr_d  = grant_id;
        end
        if (state_q == EXEC) begin
            rsp_valid_d    = 1'b1;
            rsp_id_d       = id_q;
            rsp_result_d   = alu_result;
            rsp_overflow_d = alu_overflow;
            rsp_zero_d     = alu_zero;
            rsp_equal_d    = alu_equal;
        end
        if (rsp_fire) rsp_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand and response registers are reset so a mid-op reset leaves nothing stale.
        if (!rst_n) begin
            rr_ptr_q       <= IDW'(NREQ - 1);
            id_q           <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_ctrl_q      <= ALU_AND;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_equal_q    <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            id_q           <= id_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            op_ctrl_q      <= op_ctrl_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_equal_q    <= rsp_equal_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_equal    = rsp_equal_q;

`ifdef ALU_ARB_STATS_EN
    logic [31:0] ops_count_q, ops_count_d;
    logic [15:0] ovf_count_q, ovf_count_d;

    always_comb begin
        ops_count_d = ops_count_q;
        ovf_count_d = ovf_count_q;
        if (rsp_fire) begin
            ops_count_d = ops_count_q + 32'd1;
            if (rsp_overflow_q && ovf_count_q != 16'hFFFF) ovf_count_d = ovf_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_count_q <= '0;
            ovf_count_q <= '0;
        end else begin
            ops_count_q <= ops_count_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ops_count = ops_count_q;
    assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a cycle-level request/handshake model predicts
// grants and pushes expected responses; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_types::*;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);
    localparam int CW   = $bits(alu_control_t);
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*N-1:0]  req_a;
    logic [NREQ*N-1:0]  req_b;
    logic [NREQ*CW-1:0] req_control;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [N-1:0]       rsp_result;
    logic               rsp_overflow, rsp_zero, rsp_equal;
`ifdef ALU_ARB_STATS_EN
    logic [31:0]        ops_count;
    logic [15:0]        ovf_count;
`endif

    alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_control  (req_control),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_equal    (rsp_equal)
`ifdef ALU_ARB_STATS_EN
        ,
        .ops_count    (ops_count),
        .ovf_count    (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [N-1:0]   result;
        logic           ovf;
        logic           zero;
        logic           eq;
    } rsp_t;

    rsp_t         exp_q[$];
    int           grant_log[$];
    int           checks = 0;
    int           errors = 0;
    logic         drv_valid [NREQ];
    logic [N-1:0] drv_a     [NREQ];
    logic [N-1:0] drv_b     [NREQ];
    alu_control_t drv_ctrl  [NREQ];
    logic         drv_rsp_ready;
    int           m_stage;   // 0 free, 1 computing, 2 holding a response
    int           m_ptr;
    int           m_ops;
    int           m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t ref_alu(input int id, input logic [31:0] a, input logic [31:0] b,
                                     input alu_control_t c);
        rsp_t   r;
        longint sa, sb, wide;
        sa       = longint'($signed(a));
        sb       = longint'($signed(b));
        wide     = 0;
        r.id     = IDW'(id);
        r.result = '0;
        r.ovf    = 1'b0;
        case (c)
            ALU_AND: r.result = a & b;
            ALU_OR:  r.result = a | b;
            ALU_NOR: r.result = ~(a | b);
            ALU_ADD: begin wide = sa + sb; r.result = wide[31:0]; r.ovf = (wide > SMAX) || (wide < SMIN); end
            ALU_SUB: begin wide = sa - sb; r.result = wide[31:0]; r.ovf = (wide > SMAX) || (wide < SMIN); end
            ALU_SLT: r.result = (sa < sb) ? 32'd1 : 32'd0;
            default: r.result = '0;
        endcase
        r.zero = (r.result == 0);
        r.eq   = (a == b);
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic alu_control_t rand_ctrl();
        case ($urandom_range(0, 5))
            0:       return ALU_AND;
            1:       return ALU_OR;
            2:       return ALU_NOR;
            3:       return ALU_SUB;
            4:       return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]            = drv_valid[i];
            req_a[i*N +: N]         = drv_a[i];
            req_b[i*N +: N]         = drv_b[i];
            req_control[i*CW +: CW] = drv_ctrl[i];
        end
        rsp_ready = drv_rsp_ready;
    endtask

    // One clock: drive at negedge, compare grant/valid timing, then advance the model.
    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        int              w;
        int              idx;
        @(negedge clk);
        apply();
        #1;
        exp_ready = '0;
        w         = -1;
        if (m_stage == 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (w < 0 && drv_valid[idx]) w = idx;
            end
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid_timing", 32'(rsp_valid), 32'(m_stage == 2));
        case (m_stage)
            0: if (w >= 0) begin
                exp_q.push_back(ref_alu(w, drv_a[w], drv_b[w], drv_ctrl[w]));
                grant_log.push_back(w);
                m_ptr        = w;
                drv_valid[w] = 1'b0;
                m_stage      = 1;
            end
            1: m_stage = 2;
            default: if (drv_rsp_ready) m_stage = 0;
        endcase
    endtask

    task automatic drain(input int budget);
        int n = 0;
        drv_rsp_ready = 1'b1;
        while ((m_stage != 0 || exp_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (m_stage != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding after %0d cycles, expected 0",
                     exp_q.size(), budget);
        end
    endtask

    // Asynchronous reset between edges, with every requester asking for service.
    task automatic do_reset();
        #2;
        for (int i = 0; i < NREQ; i++) drv_valid[i] = 1'b1;
        apply();
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        m_stage = 0;
        m_ptr   = NREQ - 1;
        m_ops   = 0;
        m_ovf   = 0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle a response is presented it must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got response id %0d expected none", rsp_id);
                end else begin
                    check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                    check("rsp_result", rsp_result, exp_q[0].result);
                    check("rsp_overflow", 32'(rsp_overflow), 32'(exp_q[0].ovf));
                    check("rsp_zero", 32'(rsp_zero), 32'(exp_q[0].zero));
                    check("rsp_equal", 32'(rsp_equal), 32'(exp_q[0].eq));
                    if (rsp_ready) begin
                        m_ops++;
                        if (exp_q[0].ovf) m_ovf++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            drv_valid[i] = 1'b1;
            drv_a[i]     = '0;
            drv_b[i]     = '0;
            drv_ctrl[i]  = ALU_ADD;
        end
        drv_rsp_ready = 1'b1;
        m_stage = 0;
        m_ptr   = NREQ - 1;
        m_ops   = 0;
        m_ovf   = 0;
        rst_n   = 1'b0;
        apply();
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        for (int i = 0; i < NREQ; i++) drv_valid[i] = 1'b0;
        apply();
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, no contention.
        drv_valid[0] = 1'b1; drv_a[0] = 32'h0000_0005; drv_b[0] = 32'h0000_0003; drv_ctrl[0] = ALU_ADD;
        cycle();
        drain(20);

        // Overflow path from requester 2.
        drv_valid[2] = 1'b1; drv_a[2] = 32'h7FFF_FFFF; drv_b[2] = 32'h0000_0001; drv_ctrl[2] = ALU_ADD;
        cycle();
        drain(20);
`ifdef ALU_ARB_STATS_EN
        check("ops_count_early", ops_count, 32'(m_ops));
        check("ovf_count_early", 32'(ovf_count), 32'(m_ovf));
`endif

        // Full contention from a fresh reset: strict 0,1,2,3 rotation.
        for (int i = 0; i < NREQ; i++) begin
            drv_a[i] = 32'(i); drv_b[i] = 32'(i); drv_ctrl[i] = ALU_SUB;
        end
        do_reset();
        grant_log.delete();
        for (int n = 0; n < 200 && grant_log.size() < 12; n++) begin
            for (int i = 0; i < NREQ; i++) drv_valid[i] = 1'b1;
            cycle();
        end
        for (int i = 0; i < NREQ; i++) drv_valid[i] = 1'b0;
        drain(20);
        check("fair_count", 32'(grant_log.size()), 32'd12);
        for (int k = 0; k < 12 && k < grant_log.size(); k++)
            check("fair_order", 32'(grant_log[k]), 32'(k % NREQ));

        // Response backpressure with all requesters waiting.
        drv_valid[3] = 1'b1; drv_a[3] = rand_operand(); drv_b[3] = rand_operand(); drv_ctrl[3] = rand_ctrl();
        drv_rsp_ready = 1'b0;
        cycle();
        cycle();
        for (int i = 0; i < NREQ; i++) begin
            drv_valid[i] = 1'b1; drv_a[i] = rand_operand(); drv_b[i] = rand_operand(); drv_ctrl[i] = rand_ctrl();
        end
        repeat (5) cycle();
        drv_rsp_ready = 1'b1;
        cycle();
        grant_log.delete();
        cycle();
        check("bp_next_accept", 32'(grant_log.size()), 32'd1);
        for (int i = 0; i < NREQ; i++) drv_valid[i] = 1'b0;
        drain(20);

        // Reset while computing, then while holding a response.
        drv_valid[1] = 1'b1; drv_a[1] = 32'd9; drv_b[1] = 32'd4; drv_ctrl[1] = ALU_SUB;
        cycle();
        do_reset();
        cycle();
        for (int i = 0; i < NREQ; i++) drv_valid[i] = 1'b0;
        drain(20);
        drv_valid[2] = 1'b1; drv_a[2] = 32'd1; drv_b[2] = 32'd2; drv_ctrl[2] = ALU_SLT;
        drv_rsp_ready = 1'b0;
        cycle();
        cycle();
        cycle();
        do_reset();
        cycle();
        for (int i = 0; i < NREQ; i++) drv_valid[i] = 1'b0;
        drain(20);

        // Randomized traffic with withdrawals and backpressure.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (drv_valid[i]) begin
                    if ($urandom_range(0, 19) == 0) drv_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    drv_valid[i] = 1'b1;
                    drv_a[i]     = rand_operand();
                    drv_b[i]     = rand_operand();
                    drv_ctrl[i]  = rand_ctrl();
                end
            end
            drv_rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        for (int i = 0; i < NREQ; i++) drv_valid[i] = 1'b0;
        drain(20);

`ifdef ALU_ARB_STATS_EN
        check("ops_count", ops_count, 32'(m_ops));
        check("ovf_count", 32'(ovf_count), 32'(m_ovf));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
